mant_mul_54b: RTL and testbench

- Sequencer for the FP multiply datapath that builds a 54x54 unsigned mantissa product from one shared 18x18 multiplier (karatsuba_18b).
- Splits each operand into three 18-bit limbs and issues up to 9 limb products to the multiplier over its start/done handshake.
- Shifts and accumulates the returned 36-bit results into a 108-bit product.
- Sits upstream of karatsuba_18b, feeding its operands, and downstream of it, consuming its products. The multiplier connects through the m_* ports.

---
 rtl/mant_mul_54b.sv | 117 +++++++++++
 tb/tb_mant_mul_54b.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mant_mul_54b.sv
// 54x54 unsigned mantissa multiplier built from one shared 18x18 multiplier.
// Limb pairs with a zero operand are skipped; the remaining partial products are shifted and accumulated.
module mant_mul_54b #(
  parameter int LIMB_W  = 18,
  parameter int N_LIMBS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [LIMB_W*N_LIMBS-1:0]     a,
  input  logic [LIMB_W*N_LIMBS-1:0]     b,
  output logic [2*LIMB_W*N_LIMBS-1:0]   p,
  output logic                          busy,
  output logic                          done,
  output logic                          m_start,
  output logic [LIMB_W-1:0]             m_a,
  output logic [LIMB_W-1:0]             m_b,
  input  logic [2*LIMB_W-1:0]           m_s,
  input  logic                          m_done
);

  localparam int OP_W = LIMB_W * N_LIMBS;
  localparam int PR_W = 2 * OP_W;
  localparam int LI_W = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;
  localparam logic [LI_W-1:0] LAST = LI_W'(N_LIMBS - 1);

  typedef enum logic [2:0] {IDLE, SEL, ISSUE, WAIT, FIN} state_t;

  state_t            state, state_nxt;
  logic [OP_W-1:0]   a_r, b_r;
  logic [PR_W-1:0]   acc;
  logic [LI_W-1:0]   ii, jj;
  logic              iss_cnt;
  logic [LIMB_W-1:0] a_limb, b_limb;
  logic [PR_W-1:0]   pp_shift;
  logic              skip, last, accept, advance;

  assign a_limb   = a_r[int'(ii) * LIMB_W +: LIMB_W];
  assign b_limb   = b_r[int'(jj) * LIMB_W +: LIMB_W];
  assign skip     = (a_limb == '0) || (b_limb == '0);
  assign last     = (ii == LAST) && (jj == LAST);
  assign accept   = (state == IDLE) && start;
  assign advance  = ((state == SEL) && skip) || ((state == WAIT) && m_done);
  assign pp_shift = PR_W'(m_s) << (LIMB_W * (int'(ii) + int'(jj)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEL;
      SEL:     if (!skip) state_nxt = ISSUE;
               else       state_nxt = last ? FIN : SEL;
      ISSUE:   if (iss_cnt) state_nxt = WAIT;
      WAIT:    if (m_done) state_nxt = last ? FIN : SEL;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, limb walk, multiplier handshake and accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      ii      <= '0;
      jj      <= '0;
      iss_cnt <= 1'b0;
      p       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      m_start <= 1'b0;
      m_a     <= '0;
      m_b     <= '0;
    end else begin
      if (accept) begin
        a_r  <= a;
        b_r  <= b;
        acc  <= '0;
        ii   <= '0;
        jj   <= '0;
        busy <= 1'b1;
        done <= 1'b0;
      end
      if ((state == SEL) && !skip) begin
        m_a     <= a_limb;
        m_b     <= b_limb;
        m_start <= 1'b1;
        iss_cnt <= 1'b0;
      end
      if (state == ISSUE) begin
        iss_cnt <= 1'b1;
        if (iss_cnt) m_start <= 1'b0;
      end
      if ((state == WAIT) && m_done) acc <= acc + pp_shift;
      // Index stays on the final pair so limb selects never leave the operand
      if (advance && !last) begin
        if (jj == LAST) begin
          jj <= '0;
          ii <= ii + 1'b1;
        end else begin
          jj <= jj + 1'b1;
        end
      end
      if (state == FIN) begin
        p    <= acc;
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mant_mul_54b.sv
// Bench for mant_mul_54b with a latency-programmable 18x18 multiplier model and a product scoreboard.
module tb_mant_mul_54b;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [53:0]  a_in, b_in;
  logic [107:0] p;
  logic         busy, done, m_start;
  logic [17:0]  m_a, m_b;
  logic [35:0]  m_s;
  logic         m_done;

  int checks = 0;
  int failures = 0;
  int bursts = 0;
  int hi = 0;
  int lat_fix = 3;
  logic [107:0] exp_q[$];
  localparam logic [53:0] ALL1 = {54{1'b1}};

  always #5 clk = ~clk;

  mant_mul_54b u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a_in),
    .b       (b_in),
    .p       (p),
    .busy    (busy),
    .done    (done),
    .m_start (m_start),
    .m_a     (m_a),
    .m_b     (m_b),
    .m_s     (m_s),
    .m_done  (m_done)
  );

  function automatic logic [107:0] prod(input logic [53:0] x, input logic [53:0] y);
    logic [107:0] xe, ye;
    xe = {54'b0, x};
    ye = {54'b0, y};
    return xe * ye;
  endfunction

  function automatic int nz_pairs(input logic [53:0] x, input logic [53:0] y);
    int n = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (x[18*i +: 18] != 0 && y[18*j +: 18] != 0) n++;
    return n;
  endfunction

  // Multiplier model: result appears after the programmed number of WAIT cycles
  initial begin
    logic [17:0] ca, cb;
    int ms, cnt;
    m_done = 1'b0;
    m_s = '0;
    ms = 0;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      case (ms)
        0: if (m_start && rst_n) begin ca = m_a; cb = m_b; ms = 1; end
        1: if (!rst_n) ms = 0;
           else if (!m_start) begin
             cnt = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 20));
             ms = 2;
             if (cnt == 0) begin m_done = 1'b1; m_s = ca * cb; ms = 3; end
           end
        2: if (!rst_n) ms = 0;
           else begin
             cnt--;
             if (cnt == 0) begin m_done = 1'b1; m_s = ca * cb; ms = 3; end
           end
        default: begin m_done = 1'b0; ms = 0; end
      endcase
    end
  end

  initial begin
    logic ms_q = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (m_start && !ms_q) bursts++;
      if (m_start) hi++;
      ms_q = m_start;
    end
  end

  // Scoreboard: each rising done retires the oldest expected product
  initial begin
    logic done_q = 1'b0;
    logic [107:0] e;
    forever begin
      @(posedge clk); #1;
      if (done && !done_q) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_done p=%h no expected entry", p);
        end else begin
          e = exp_q.pop_front();
          if (p !== e) begin
            failures++;
            $display("FAIL sb_product got=%h want=%h", p, e);
          end
        end
      end
      done_q = done;
    end
  end

  task automatic start_op(input logic [53:0] x, input logic [53:0] y);
    @(negedge clk);
    a_in = x;
    b_in = y;
    start = 1'b1;
    exp_q.push_back(prod(x, y));
    @(posedge clk); #1;
    start = 1'b0;
    bursts = 0;
    hi = 0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout after %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({p, busy, done, m_start, m_a, m_b} !== '0) begin
      failures++;
      $display("FAIL reset_outputs p=%h busy=%b done=%b m_start=%b m_a=%h m_b=%h want all 0",
               p, busy, done, m_start, m_a, m_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_limb();
    int cyc;
    lat_fix = 3;
    start_op(54'd1, 54'd1);
    wait_done(500, cyc);
    checks++;
    if (cyc !== 16) begin failures++; $display("FAIL one_latency got=%0d want=16", cyc); end
    checks++;
    if (bursts !== 1 || hi !== 2) begin
      failures++; $display("FAIL one_bursts bursts=%0d high=%0d want 1/2", bursts, hi);
    end
    checks++;
    if (p !== 108'd1 || done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL one_result p=%h done=%b busy=%b want 1/1/0", p, done, busy);
    end
  endtask

  task automatic test_zero();
    int cyc;
    lat_fix = 3;
    start_op(54'd0, ALL1);
    wait_done(500, cyc);
    checks++;
    if (cyc !== 10) begin failures++; $display("FAIL zero_latency got=%0d want=10", cyc); end
    checks++;
    if (bursts !== 0) begin failures++; $display("FAIL zero_bursts got=%0d want=0", bursts); end
    checks++;
    if (p !== 108'd0) begin failures++; $display("FAIL zero_result got=%h want=0", p); end
  endtask

  task automatic test_all_ones();
    int cyc;
    logic [107:0] want;
    want = ~108'd0 - (108'd1 << 55) + 108'd2;
    lat_fix = 3;
    start_op(ALL1, ALL1);
    wait_done(1000, cyc);
    checks++;
    if (cyc !== 64) begin failures++; $display("FAIL ones_latency got=%0d want=64", cyc); end
    checks++;
    if (bursts !== 9 || hi !== 18) begin
      failures++; $display("FAIL ones_bursts bursts=%0d high=%0d want 9/18", bursts, hi);
    end
    checks++;
    if (p !== want) begin failures++; $display("FAIL ones_result got=%h want=%h", p, want); end
  endtask

  task automatic test_done_accept();
    int cyc;
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL accept_pre_done got=%b want=1", done); end
    start_op(54'd7, 54'd9);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL accept_edge done=%b busy=%b want 0/1", done, busy);
    end
    wait_done(500, cyc);
    checks++;
    if (p !== 108'd63) begin failures++; $display("FAIL accept_result got=%h want=63", p); end
  endtask

  task automatic test_reset_mid();
    int n, cyc;
    lat_fix = 3;
    start_op(ALL1, ALL1);
    n = 0;
    while (!(bursts == 5 && !m_start) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 500) begin failures++; $display("FAIL abort_reach_wait5 bursts=%0d want 5", bursts); end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({p, busy, done, m_start, m_a, m_b} !== '0) begin
      failures++;
      $display("FAIL abort_outputs p=%h busy=%b done=%b m_start=%b m_a=%h m_b=%h want all 0",
               p, busy, done, m_start, m_a, m_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    start_op(54'd3, 54'd5);
    wait_done(500, cyc);
    checks++;
    if (p !== 108'd15 || bursts !== 1) begin
      failures++; $display("FAIL abort_recover p=%h bursts=%0d want 15/1", p, bursts);
    end
  endtask

  task automatic test_random();
    logic [63:0] r;
    logic [53:0] ra, rb;
    int cyc, nz;
    lat_fix = 0;
    for (int n = 0; n < 300; n++) begin
      r = {$urandom(), $urandom()};
      ra = r[53:0];
      r = {$urandom(), $urandom()};
      rb = r[53:0];
      case (n % 4)
        1: ra[18*$urandom_range(0, 2) +: 18] = '0;
        2: rb[18*$urandom_range(0, 2) +: 18] = '0;
        3: begin
          ra[18*$urandom_range(0, 2) +: 18] = '0;
          rb[18*$urandom_range(0, 2) +: 18] = '0;
        end
        default: ;
      endcase
      nz = nz_pairs(ra, rb);
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL rand_done_held op=%0d got=%b want=1", n, done); end
      start_op(ra, rb);
      if (n % 3 == 0) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        @(negedge clk);
        a_in = ~ra;
        b_in = rb ^ 54'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_done(3000, cyc);
      checks++;
      if (bursts !== nz || hi !== 2 * nz) begin
        failures++;
        $display("FAIL rand_bursts op=%0d bursts=%0d high=%0d want %0d/%0d", n, bursts, hi, nz, 2 * nz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_limb();
    test_zero();
    test_all_ones();
    test_done_accept();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover got=%0d entries want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
